maxpool2x2_stream: RTL and testbench

//  Streaming 2x2 stride-2 max-pooling stage placed directly downstream of the ReLU stage.
//  - Consumes one signed 16-bit activation per valid cycle, in raster order over an IMG_W x IMG_H feature map.
//  - Emits one pooled value per 2x2 window, in raster order over an (IMG_W/2) x (IMG_H/2) map.
//  - No backpressure: the producer pushes and this block always accepts.

---
 rtl/maxpool2x2_stream_pkg.sv | 15 +
 rtl/maxpool2x2_stream_pool_line_buf.sv | 28 ++
 rtl/maxpool2x2_stream.sv | 125 ++++++++++++
 tb/tb_maxpool2x2_stream.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/maxpool2x2_stream_pkg.sv
// Shared definitions for the pooling stage and later stages of the activation pipeline.
package maxpool2x2_stream_pkg;

    // Activation width used throughout the pipeline.
    localparam int ACT_W = 16;

    // Signed maximum of two activations. Ties return b; both operands are equal then.
    function automatic logic signed [ACT_W-1:0] smax(
        input logic signed [ACT_W-1:0] a,
        input logic signed [ACT_W-1:0] b
    );
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/maxpool2x2_stream_pool_line_buf.sv
// Register-array line buffer holding one row of horizontal pair maxima.
// One write port and one combinational read port. Contents are not reset:
// every entry is written on an even row before it is read on the following odd row.
module pool_line_buf #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 16,
    parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Store a pair maximum when the even row finishes a pair.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/maxpool2x2_stream.sv
// Streaming 2x2 stride-2 max pool over a raster-ordered IMG_W x IMG_H feature map.
//
// Interface semantics: valid_in qualifies in_data and sof_in for one cycle and is
// always accepted (there is no ready). valid_out is a one-cycle pulse qualifying
// out_data and eof_out; the consumer must take it in that cycle.
module maxpool2x2_stream
    import maxpool2x2_stream_pkg::*;
#(
    parameter int DATA_W = ACT_W,
    parameter int IMG_W  = 8,
    parameter int IMG_H  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              sof_in,
    input  logic [DATA_W-1:0] in_data,
    input  logic              valid_in,
    output logic [DATA_W-1:0] out_data,
    output logic              valid_out,
    output logic              eof_out
);

    localparam int HALF_W = IMG_W / 2;
    localparam int COL_W  = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int ROW_W  = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int AW     = (HALF_W > 1) ? $clog2(HALF_W) : 1;
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_H - 1);

    // Refuse to build for geometries that cannot tile into 2x2 windows.
    if ((IMG_W % 2) != 0 || IMG_W < 2) begin : g_bad_img_w
        $error("maxpool2x2_stream: IMG_W must be even and >= 2");
    end
    if ((IMG_H % 2) != 0 || IMG_H < 2) begin : g_bad_img_h
        $error("maxpool2x2_stream: IMG_H must be even and >= 2");
    end
    if (DATA_W != ACT_W) begin : g_bad_data_w
        $error("maxpool2x2_stream: DATA_W must equal the pipeline ACT_W");
    end

    logic [COL_W-1:0]  col_q, col_d;
    logic [ROW_W-1:0]  row_q, row_d;
    logic [DATA_W-1:0] half_q, half_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              valid_q, valid_d;
    logic              eof_q, eof_d;

    logic [COL_W-1:0]  eff_col;
    logic [ROW_W-1:0]  eff_row;
    logic [DATA_W-1:0] pmax;
    logic              lb_we;
    logic [AW-1:0]     lb_addr;
    logic [DATA_W-1:0] lb_rdata;

    pool_line_buf #(
        .DEPTH (HALF_W),
        .WIDTH (DATA_W),
        .AW    (AW)
    ) u_line_buf (
        .clk   (clk),
        .we    (lb_we),
        .waddr (lb_addr),
        .wdata (pmax),
        .raddr (lb_addr),
        .rdata (lb_rdata)
    );

    // Position tracking, horizontal/vertical pooling and output formation.
    // sof_in forces the current pixel to (0,0), discarding any partial window.
    always_comb begin
        eff_col    = sof_in ? '0 : col_q;
        eff_row    = sof_in ? '0 : row_q;
        col_d      = col_q;
        row_d      = row_q;
        half_d     = half_q;
        out_data_d = out_data_q;
        valid_d    = 1'b0;
        eof_d      = 1'b0;
        lb_we      = 1'b0;
        lb_addr    = AW'(eff_col >> 1);
        pmax       = smax(half_q, in_data);
        if (valid_in) begin
            if (eff_col == COL_LAST) begin
                col_d = '0;
                row_d = (eff_row == ROW_LAST) ? '0 : eff_row + 1'b1;
            end else begin
                col_d = eff_col + 1'b1;
                row_d = eff_row;
            end
            if (!eff_col[0]) begin
                half_d = in_data;
            end else if (!eff_row[0]) begin
                lb_we = 1'b1;
            end else begin
                valid_d    = 1'b1;
                out_data_d = smax(lb_rdata, pmax);
                eof_d      = (eff_col == COL_LAST) && (eff_row == ROW_LAST);
            end
        end
    end

    // State and output registers; reset clears everything except the line buffer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_q      <= '0;
            row_q      <= '0;
            half_q     <= '0;
            out_data_q <= '0;
            valid_q    <= 1'b0;
            eof_q      <= 1'b0;
        end else begin
            col_q      <= col_d;
            row_q      <= row_d;
            half_q     <= half_d;
            out_data_q <= out_data_d;
            valid_q    <= valid_d;
            eof_q      <= eof_d;
        end
    end

    assign out_data  = out_data_q;
    assign valid_out = valid_q;
    assign eof_out   = eof_q;

endmodule

// File: tb/tb_maxpool2x2_stream.sv
// Testbench for maxpool2x2_stream with a 4x4 map.
module tb_maxpool2x2_stream;

    localparam int W  = 16;
    localparam int IW = 4;
    localparam int IH = 4;

    logic          clk;
    logic          rst_n;
    logic          sof_in;
    logic [W-1:0]  in_data;
    logic          valid_in;
    logic [W-1:0]  out_data;
    logic          valid_out;
    logic          eof_out;

    maxpool2x2_stream #(.DATA_W(W), .IMG_W(IW), .IMG_H(IH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sof_in    (sof_in),
        .in_data   (in_data),
        .valid_in  (valid_in),
        .out_data  (out_data),
        .valid_out (valid_out),
        .eof_out   (eof_out)
    );

    // ---------------- clock / reset ----------------
    int cyc = 0;
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard state ----------------
    logic [W:0]   exp_q[$];      // {eof, data}
    int           exp_cyc_q[$];  // cycle at which the output must appear
    logic [W:0]   obs_q[$];      // everything the DUT emitted in the current test
    logic [W:0]   want[$];       // directed expectations for the current test
    int           n_checks = 0;
    int           n_fail   = 0;

    // Reference model: whole-frame picture plus a raster position.
    logic [W-1:0] img [IH][IW];
    int           mr = 0;
    int           mc = 0;

    logic [W-1:0] f1 [16] = '{16'd1, 16'd5, 16'd2, 16'd3,
                              16'd4, 16'd0, 16'd8, 16'd7,
                              16'd9, 16'd9, 16'd0, 16'd1,
                              16'd2, 16'd3, 16'd6, 16'd4};

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mr = 0;
        mc = 0;
        exp_q.delete();
        exp_cyc_q.delete();
    endtask

    task automatic model_accept(input logic [W-1:0] d, input bit sof);
        int best;
        int v;
        if (sof) begin
            mr = 0;
            mc = 0;
        end
        img[mr][mc] = d;
        if ((mr % 2 == 1) && (mc % 2 == 1)) begin
            best = $signed(img[mr][mc]);
            for (int dr = 0; dr < 2; dr++) begin
                for (int dc = 0; dc < 2; dc++) begin
                    v = $signed(img[mr-dr][mc-dc]);
                    if (v > best) best = v;
                end
            end
            exp_q.push_back({(mr == IH-1) && (mc == IW-1), best[W-1:0]});
            exp_cyc_q.push_back(cyc + 1);
        end
        mc++;
        if (mc == IW) begin
            mc = 0;
            mr = (mr + 1) % IH;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [W-1:0] d, input bit s);
        @(negedge clk);
        in_data  = d;
        sof_in   = s;
        valid_in = 1'b1;
        model_accept(d, s);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            valid_in = 1'b0;
            sof_in   = 1'b0;
            in_data  = W'($urandom);
        end
    endtask

    task automatic send_frame(input logic [W-1:0] px [16], input int max_bub, input bit first_sof);
        for (int i = 0; i < 16; i++) begin
            drive(px[i], first_sof && (i == 0));
            if (max_bub > 0) idle($urandom_range(0, max_bub));
        end
        idle(1);
    endtask

    task automatic check_seq(input string nm);
        check({nm, "_count"}, obs_q.size(), want.size());
        for (int i = 0; i < obs_q.size() && i < want.size(); i++) begin
            check($sformatf("%s_out%0d", nm, i), obs_q[i], want[i]);
        end
        obs_q.delete();
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        logic [W:0] e;
        int         ec;
        if (rst_n) begin
            if (valid_out) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_out: got %0h expected no output (t=%0t)", out_data, $time);
                end else begin
                    e  = exp_q.pop_front();
                    ec = exp_cyc_q.pop_front();
                    check("out_data", out_data, e[W-1:0]);
                    check("eof_out", eof_out, e[W]);
                    check("latency_cycle", cyc, ec);
                end
                obs_q.push_back({eof_out, out_data});
            end else begin
                check("eof_idle", eof_out, 0);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [W-1:0] px [16];
        rst_n    = 1'b0;
        valid_in = 1'b0;
        sof_in   = 1'b0;
        in_data  = '0;
        repeat (2) @(negedge clk);
        check("reset_out_data", out_data, 0);
        check("reset_valid", valid_out, 0);
        check("reset_eof", eof_out, 0);
        rst_n = 1'b1;
        idle(2);

        // 1: reference frame back-to-back
        want = '{17'h00005, 17'h00008, 17'h00009, 17'h10006};
        send_frame(f1, 0, 1'b1);
        idle(3);
        check_seq("t1_frame");

        // 2: same frame with random bubbles
        want = '{17'h00005, 17'h00008, 17'h00009, 17'h10006};
        send_frame(f1, 3, 1'b1);
        idle(3);
        check_seq("t2_bubbles");

        // 3: signed windows
        for (int i = 0; i < 16; i++) px[i] = W'($urandom);
        px[0] = -16'sd3;  px[1] = -16'sd1;  px[2] = 16'h8000; px[3] = 16'h7FFF;
        px[4] = -16'sd7;  px[5] = -16'sd2;  px[6] = 16'h0000; px[7] = 16'hFFFF;
        send_frame(px, 1, 1'b1);
        idle(3);
        check("t3_count", obs_q.size(), 4);
        if (obs_q.size() >= 2) begin
            check("t3_neg_window", obs_q[0][W-1:0], 16'hFFFF);
            check("t3_extreme_window", obs_q[1][W-1:0], 16'h7FFF);
        end
        obs_q.delete();

        // 4: asynchronous reset mid row 2, then a frame of 10s without sof
        for (int i = 0; i < 10; i++) drive(f1[i], i == 0);
        @(negedge clk);
        valid_in = 1'b0;
        rst_n    = 1'b0;
        #1;
        check("t4_rst_out_data", out_data, 0);
        check("t4_rst_valid", valid_out, 0);
        check("t4_rst_eof", eof_out, 0);
        model_reset();
        obs_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) px[i] = 16'd10;
        want = '{17'h0000A, 17'h0000A, 17'h0000A, 17'h1000A};
        send_frame(px, 0, 1'b0);
        idle(3);
        check_seq("t4_after_reset");

        // 5: sof at (2,1) of frame A restarts on frame B
        for (int i = 0; i < 9; i++) drive(f1[i], i == 0);
        want = '{17'h00005, 17'h00008, 17'h00005, 17'h00008, 17'h00009, 17'h10006};
        send_frame(f1, 0, 1'b1);
        idle(3);
        check_seq("t5_sof_restart");

        // 6: two frames without a gap, second one relying on counter wrap
        for (int i = 0; i < 16; i++) drive(f1[i], i == 0);
        send_frame(f1, 0, 1'b0);
        want = '{17'h00005, 17'h00008, 17'h00009, 17'h10006,
                 17'h00005, 17'h00008, 17'h00009, 17'h10006};
        idle(3);
        check_seq("t6_two_frames");

        // 7: random signed frames, random bubbles, occasional mid-frame sof
        for (int f = 0; f < 12; f++) begin
            if ($urandom_range(0, 3) == 0) begin
                for (int i = 0; i < $urandom_range(1, 14); i++) drive(W'($urandom), 1'b0);
            end
            for (int i = 0; i < 16; i++) px[i] = W'($urandom);
            send_frame(px, $urandom_range(0, 2), $urandom_range(0, 1) == 1);
        end
        idle(4);
        obs_q.delete();
        check("drain_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
